// File: rtl/seg7_pkg.sv
// seg7_pkg: shared widths, special display codes and the hex glyph table
// for the seven-segment scan driver (segment order seg[6]=A .. seg[0]=G).
`default_nettype none

package seg7_pkg;

  localparam int CODE_W     = 5;
  localparam int SEG_W      = 7;
  localparam int CODE_BLANK = 16;
  localparam int CODE_DASH  = 17;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [SEG_W-1:0]  seg_t;

  localparam seg_t SEG_OFF  = 7'b0000000;
  localparam seg_t SEG_DASH = 7'b0000001;

  localparam seg_t GLYPH_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 5-bit display code to active-high segment pattern.
`default_nettype none

module seg7_decode
  import seg7_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SEG_W-1:0]  seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (!code_i[CODE_W-1]) begin
      seg_o = GLYPH_TABLE[code_i[3:0]];
    end else if (code_i == code_t'(CODE_DASH)) begin
      seg_o = SEG_DASH;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed N-digit 7-seg scanner with tear-free staged loads.
// Optional blink support compiled in with macro SEG7_SCAN_BLINK_EN.
`default_nettype none

module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000
`ifdef SEG7_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CODE_W*N_DIGITS-1:0] codes,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic                       enable,
`ifdef SEG7_SCAN_BLINK_EN
  input  logic [N_DIGITS-1:0]        blink_mask,
`endif
  output logic [N_DIGITS-1:0]        an,
  output logic [SEG_W-1:0]           seg,
  output logic                       frame_start
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BUS_W = CODE_W * N_DIGITS;
  localparam logic [BUS_W-1:0] BLANK_ALL = {N_DIGITS{code_t'(CODE_BLANK)}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                pending_q, pending_d;
  logic                ready_q, ready_d;
  logic [BUS_W-1:0]    stage_q, stage_d;
  logic [BUS_W-1:0]    disp_q, disp_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic                fs_q, fs_d;

  logic                tick, wrap, accept;
  logic [N_DIGITS-1:0] an_sel;
  logic [CODE_W-1:0]   cur_code;
  logic [SEG_W-1:0]    cur_seg;
  logic                lit;

  seg7_decode u_decode (
    .code_i (cur_code),
    .seg_o  (cur_seg)
  );

`ifdef SEG7_SCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic            phase_off_q, phase_off_d;

  always_comb begin
    fcnt_d      = fcnt_q;
    phase_off_d = phase_off_q;
    if (wrap) begin
      if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        fcnt_d      = '0;
        phase_off_d = !phase_off_q;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
    lit = enable && !(phase_off_q && |(an_sel & blink_mask));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q      <= '0;
      phase_off_q <= 1'b0;
    end else begin
      fcnt_q      <= fcnt_d;
      phase_off_q <= phase_off_d;
    end
  end
`else
  assign lit = enable;
`endif

  always_comb begin
    tick   = (cnt_q == CNT_W'(DIV - 1));
    wrap   = tick && (idx_q == IDX_W'(N_DIGITS - 1));
    accept = load_valid && ready_q;

    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end

    // Display only ever changes on the frame wrap, so a frame never mixes old and new codes.
    disp_d    = disp_q;
    stage_d   = stage_q;
    pending_d = pending_q;
    if (wrap && pending_q) begin
      disp_d    = stage_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      stage_d   = codes;
      pending_d = 1'b1;
    end
    ready_d = !pending_d;

    cur_code = disp_q[CODE_W-1:0];
    for (int i = 0; i < N_DIGITS; i++) begin
      an_sel[i] = (idx_q == IDX_W'(i));
      if (an_sel[i]) begin
        cur_code = disp_q[CODE_W*i +: CODE_W];
      end
    end

    an_d  = enable ? ~an_sel : '1;
    seg_d = lit ? cur_seg : SEG_OFF;
    fs_d  = wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      stage_q   <= BLANK_ALL;
      disp_q    <= BLANK_ALL;
      an_q      <= '1;
      seg_q     <= SEG_OFF;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      stage_q   <= stage_d;
      disp_q    <= disp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      fs_q      <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = fs_q;
  assign load_ready  = ready_q;

endmodule

`default_nettype wire
